// File: rtl/arb_pkg.sv
// Shared types and sizing for the write-back port arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/decoder3to8.sv
// Binary-to-one-hot decoder feeding the write-back mux select.
module decoder3to8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [N_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write-back port:
// one grant per burst (capped at MAX_BURST beats), one idle cycle between grants.
module wb_port_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             accept
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    // Rotate so that bit 0 is the unit at base, take the lowest set bit,
    // then map the offset back to an absolute unit index.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                                 input logic [IDX_W-1:0] base);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        logic               found;
        dbl   = {req_v, req_v} >> base;
        rot   = dbl[N_REQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                off   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return base + off;
    endfunction

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy;
    logic             beat_ok;
    logic             release_burst;
    logic [N_REQ-1:0] dec_onehot;

    decoder3to8 u_dec (
        .idx_i    (idx_q),
        .onehot_o (dec_onehot)
    );

    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every variable gets a default at the top of the combinational
    // block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, ptr_q);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (beat_ok) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (release_burst) begin
                    ptr_d   = idx_q + 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // An abort (granted unit drops req) releases without counting a beat.
    always_comb begin
        busy          = (state_q == BUSY);
        beat_ok       = busy & out_ready & req[idx_q];
        release_burst = busy & ((beat_ok & (last[idx_q] | (cnt_q == LAST_BEAT)))
                                | ~req[idx_q]);
        gnt_valid     = busy;
        gnt_idx       = idx_q;
        accept        = beat_ok & rst_n;
        gnt           = dec_onehot & {N_REQ{busy}};
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench: stimulus pushes the expected outputs of each
// cycle, a negedge monitor pops and compares them.
module tb_wb_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'hFF;
    logic [7:0] last = 8'hFF;
    logic       out_ready = 1'b1;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       accept;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       ev;
        logic [2:0] ei;
        logic       ea;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    wb_port_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .accept    (accept)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One stimulus cycle: drive inputs just after the edge and record what
    // the outputs must show before the next edge.
    task automatic cyc(input logic rn, input logic [7:0] rq, input logic [7:0] lt,
                       input logic rdy, input logic ev, input logic [2:0] ei,
                       input logic ea, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rn;
        req       = rq;
        last      = lt;
        out_ready = rdy;
        e.ev = ev;
        e.ei = ei;
        e.ea = ea;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] exp_gnt;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e       = exp_q.pop_front();
                exp_gnt = e.ev ? (8'h01 << e.ei) : 8'h00;
                check({e.nm, ".gnt_valid"}, {31'd0, gnt_valid}, {31'd0, e.ev});
                check({e.nm, ".gnt"}, {24'd0, gnt}, {24'd0, exp_gnt});
                check({e.nm, ".accept"}, {31'd0, accept}, {31'd0, e.ea});
                if (e.ev || e.nm == "reset")
                    check({e.nm, ".gnt_idx"}, {29'd0, gnt_idx}, {29'd0, e.ei});
            end
        end
    end

    initial begin : stimulus
        int budget;

        // Reset held two cycles with every unit requesting.
        cyc(0, 8'hFF, 8'hFF, 1, 0, 0, 0, "reset");
        cyc(0, 8'hFF, 8'hFF, 1, 0, 0, 0, "reset");

        // Single request from unit 3, then ptr=4 shown by the next pick.
        cyc(1, 8'h08, 8'h08, 1, 0, 0, 0, "single_idle");
        cyc(1, 8'h08, 8'h08, 1, 1, 3, 1, "single_gnt");
        cyc(1, 8'hFF, 8'hFF, 1, 0, 0, 0, "single_rel");
        cyc(1, 8'hFF, 8'hFF, 1, 1, 4, 1, "ptr_after_3");

        // Re-reset, then full rotation 0..7,0 with a bubble between grants.
        cyc(0, 8'hFF, 8'hFF, 1, 0, 0, 0, "rot_rst");
        cyc(1, 8'hFF, 8'hFF, 1, 0, 0, 0, "reset");
        for (int k = 0; k < 9; k++) begin
            cyc(1, 8'hFF, 8'hFF, 1, 1, 3'(k % 8), 1, $sformatf("rot_gnt%0d", k));
            cyc(1, (k == 8) ? 8'h00 : 8'hFF, 8'hFF, 1, 0, 0, 0, $sformatf("rot_bub%0d", k));
        end

        // Burst cap of 4 beats; last of other units must be ignored.
        cyc(1, 8'h01, 8'hFE, 1, 0, 0, 0, "cap_idle");
        for (int k = 0; k < 4; k++)
            cyc(1, 8'h01, 8'hFE, 1, 1, 0, 1, $sformatf("cap_beat%0d", k));
        cyc(1, 8'h01, 8'hFE, 1, 0, 0, 0, "cap_bubble");
        cyc(1, 8'h01, 8'h01, 1, 1, 0, 1, "cap_regrant");
        cyc(1, 8'h00, 8'h00, 1, 0, 0, 0, "cap_done");

        // Unit 5 stalled by out_ready=0, then aborts; next pick starts at 6.
        cyc(1, 8'h20, 8'h00, 0, 0, 0, 0, "stall_idle");
        for (int k = 0; k < 10; k++)
            cyc(1, 8'h20, 8'h00, 0, 1, 5, 0, $sformatf("stall%0d", k));
        cyc(1, 8'h00, 8'h00, 0, 1, 5, 0, "abort");
        cyc(1, 8'hFF, 8'hFF, 1, 0, 0, 0, "abort_rel");
        cyc(1, 8'hFF, 8'hFF, 1, 1, 6, 1, "ptr_after_abort");

        // ptr=7 with units 7 and 0 requesting: 7 first, then wrap to 0.
        cyc(1, 8'h81, 8'h81, 1, 0, 0, 0, "wrap_idle");
        cyc(1, 8'h81, 8'h81, 1, 1, 7, 1, "wrap_gnt7");
        cyc(1, 8'h81, 8'h00, 1, 0, 0, 0, "wrap_bubble");
        cyc(1, 8'h81, 8'h00, 1, 1, 0, 1, "wrap_gnt0");

        // Reset mid-burst: grant still visible but no accept, cleared next cycle.
        cyc(0, 8'h81, 8'h00, 1, 1, 0, 0, "rst_midburst");
        cyc(0, 8'h81, 8'h00, 1, 0, 0, 0, "reset");
        cyc(1, 8'h00, 8'h00, 0, 0, 0, 0, "reset");

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
